// File: rtl/iir_fold_pkg.sv
// iir_fold_pkg: shared types for the 2-fold IIR scheduler.
// Phase states and datapath mux encodings.
package iir_fold_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH0  = 2'd1,
    PH1  = 2'd2,
    WB   = 2'd3
  } state_e;

  localparam logic MUL_SEL_H1  = 1'b0;
  localparam logic MUL_SEL_H2  = 1'b1;
  localparam logic ADD_SEL_X   = 1'b0;
  localparam logic ADD_SEL_ACC = 1'b1;

endpackage

// File: rtl/iir_fold_ctrl_if.sv
// iir_fold_ctrl_if: handshake, coefficient bus and
// datapath control bundle of the IIR fold scheduler.
interface iir_fold_ctrl_if #(
  parameter int N = 16
) ();

  logic         in_valid;
  logic         in_ready;
  logic         clr;
  logic         coef_wr;
  logic         coef_sel;
  logic [N-1:0] coef_data;
  logic [N-1:0] h1_act;
  logic [N-1:0] h2_act;
  logic         x_ld;
  logic         mul_sel;
  logic         add_sel;
  logic         acc_ld;
  logic         y_shift;
  logic         dl_clr;
  logic         out_valid;
  logic         busy;
  logic [15:0]  sample_cnt;

  modport master (
    input  in_valid, clr,
    input  coef_wr, coef_sel, coef_data,
    output in_ready, h1_act, h2_act,
    output x_ld, mul_sel, add_sel, acc_ld,
    output y_shift, dl_clr, out_valid,
    output busy, sample_cnt
  );

  modport slave (
    output in_valid, clr,
    output coef_wr, coef_sel, coef_data,
    input  in_ready, h1_act, h2_act,
    input  x_ld, mul_sel, add_sel, acc_ld,
    input  y_shift, dl_clr, out_valid,
    input  busy, sample_cnt
  );

endinterface

// File: rtl/iir_coef_bank.sv
// iir_coef_bank: shadow/active h1,h2 registers.
// Active copies change only when a load is requested.
module iir_coef_bank #(
  parameter int N      = 16,
  parameter int H1_RST = 2,
  parameter int H2_RST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_i,
  input  logic         sel_i,
  input  logic [N-1:0] data_i,
  input  logic         ld_old_i,
  input  logic         ld_new_i,
  output logic [N-1:0] h1_o,
  output logic [N-1:0] h2_o
);

  logic [N-1:0] sh1_q, sh1_d;
  logic [N-1:0] sh2_q, sh2_d;
  logic [N-1:0] ac1_q, ac1_d;
  logic [N-1:0] ac2_q, ac2_d;

  // shadow write; active takes the pre-write shadow on an
  // accept, or the post-write shadow while idling
  always_comb begin
    sh1_d = sh1_q;
    sh2_d = sh2_q;
    ac1_d = ac1_q;
    ac2_d = ac2_q;
    if (wr_i && !sel_i) sh1_d = data_i;
    if (wr_i &&  sel_i) sh2_d = data_i;
    if (ld_old_i) begin
      ac1_d = sh1_q;
      ac2_d = sh2_q;
    end else if (ld_new_i) begin
      ac1_d = sh1_d;
      ac2_d = sh2_d;
    end
  end

  // coefficient registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh1_q <= N'(H1_RST);
      sh2_q <= N'(H2_RST);
      ac1_q <= N'(H1_RST);
      ac2_q <= N'(H2_RST);
    end else begin
      sh1_q <= sh1_d;
      sh2_q <= sh2_d;
      ac1_q <= ac1_d;
      ac2_q <= ac2_d;
    end
  end

  assign h1_o = ac1_q;
  assign h2_o = ac2_q;

endmodule

// File: rtl/iir_fold_ctrl.sv
// iir_fold_ctrl: phase FSM folding y=x+h1*y1+h2*y2 onto
// one multiplier and one adder, with sample handshake.
module iir_fold_ctrl
  import iir_fold_pkg::*;
#(
  parameter int N      = 16,
  parameter int H1_RST = 2,
  parameter int H2_RST = 4
) (
  input logic           clk,
  input logic           rst,
  iir_fold_ctrl_if.master bus
);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rst_q;
  logic        can_acc;
  logic        accept;
  logic        ld_new;
  logic        mul_sel, add_sel;
  logic        acc_ld, y_shift, out_valid;

  assign can_acc = (state_q == IDLE || state_q == WB)
                 && !rst_q;
  assign bus.in_ready = can_acc && !bus.clr;
  assign accept = bus.in_valid && bus.in_ready;
  assign ld_new = (state_q == IDLE) && !accept;

  // next state, counter and per-phase datapath controls
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_sel   = MUL_SEL_H1;
    add_sel   = ADD_SEL_X;
    acc_ld    = 1'b0;
    y_shift   = 1'b0;
    out_valid = 1'b0;
    if (bus.clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) state_d = PH0;
        end
        PH0: begin
          acc_ld  = 1'b1;
          state_d = PH1;
        end
        PH1: begin
          mul_sel = MUL_SEL_H2;
          add_sel = ADD_SEL_ACC;
          acc_ld  = 1'b1;
          state_d = WB;
        end
        WB: begin
          y_shift   = 1'b1;
          out_valid = 1'b1;
          cnt_d     = cnt_q + 16'd1;
          state_d   = accept ? PH0 : IDLE;
        end
      endcase
    end
  end

  // state, counter and reset-seen flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= 1'b0;
    end
  end

  iir_coef_bank #(
    .N      (N),
    .H1_RST (H1_RST),
    .H2_RST (H2_RST)
  ) u_coef (
    .clk      (clk),
    .rst      (rst),
    .wr_i     (bus.coef_wr),
    .sel_i    (bus.coef_sel),
    .data_i   (bus.coef_data),
    .ld_old_i (accept),
    .ld_new_i (ld_new),
    .h1_o     (bus.h1_act),
    .h2_o     (bus.h2_act)
  );

  assign bus.x_ld       = accept;
  assign bus.mul_sel    = mul_sel;
  assign bus.add_sel    = add_sel;
  assign bus.acc_ld     = acc_ld;
  assign bus.y_shift    = y_shift;
  assign bus.out_valid  = out_valid;
  assign bus.dl_clr     = rst_q || bus.clr;
  assign bus.busy       = (state_q != IDLE);
  assign bus.sample_cnt = cnt_q;

endmodule
